// File: rtl/proc_gen.sv
// proc_gen: multi-cycle processor with eight registers, A/G pair and shared bus.
// Instructions arrive on DIN under a Run/Done handshake; step FSM T0..T3.
module proc_gen #(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Run,
   input  logic [N-1:0] DIN,
   output logic         Done,
   output logic [N-1:0] BusWires,
   output logic         Zflag
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } step_t;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MVNZ = 3'b110;

   step_t        step;
   step_t        step_nxt;
   logic [8:0]   ir;
   logic [N-1:0] r [8];
   logic [N-1:0] a;
   logic [N-1:0] g;
   logic [N-1:0] alu;

   logic [2:0]   op;
   logic [7:0]   rx;
   logic [7:0]   ry;
   logic         is_alu;

   logic         ir_in;
   logic [7:0]   r_out;
   logic [7:0]   r_in;
   logic         g_out;
   logic         din_out;
   logic         a_in;
   logic         g_in;

   assign op     = ir[8:6];
   assign rx     = 8'(1) << ir[5:3];
   assign ry     = 8'(1) << ir[2:0];
   assign is_alu = (op == OP_ADD) || (op == OP_SUB) ||
                   (op == OP_AND) || (op == OP_OR);

   // Step register; reset forces T0 even mid-instruction
   always_ff @(posedge Clock) begin
      if (Reset)
         step <= T0;
      else
         step <= step_nxt;
   end

   // Next step: T0 waits for Run, T1 ends on Done, else run to T3
   always_comb begin
      step_nxt = step;
      case (step)
         T0: step_nxt = Run ? T1 : T0;
         T1: step_nxt = Done ? T0 : T2;
         T2: step_nxt = T3;
         T3: step_nxt = T0;
         default: step_nxt = T0;
      endcase
   end

   // Control signals decoded from step and IR opcode
   always_comb begin
      ir_in   = 1'b0;
      r_out   = '0;
      r_in    = '0;
      g_out   = 1'b0;
      din_out = 1'b0;
      a_in    = 1'b0;
      g_in    = 1'b0;
      Done    = 1'b0;
      case (step)
         T0: ir_in = Run;
         T1: begin
            if (is_alu) begin
               r_out = rx;
               a_in  = 1'b1;
            end else begin
               Done = 1'b1;
               case (op)
                  OP_MV: begin
                     r_out = ry;
                     r_in  = rx;
                  end
                  OP_MVI: begin
                     din_out = 1'b1;
                     r_in    = rx;
                  end
                  OP_MVNZ: begin
                     if (!Zflag) begin
                        r_out = ry;
                        r_in  = rx;
                     end
                  end
                  default: ;
               endcase
            end
         end
         T2: begin
            if (is_alu) begin
               r_out = ry;
               g_in  = 1'b1;
            end
         end
         T3: begin
            if (is_alu) begin
               g_out = 1'b1;
               r_in  = rx;
               Done  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Shared bus: one source at most, zero when idle
   always_comb begin
      BusWires = '0;
      for (int i = 0; i < 8; i++)
         if (r_out[i]) BusWires = r[i];
      if (g_out)   BusWires = g;
      if (din_out) BusWires = DIN;
   end

   // ALU: wraps modulo 2^N, carry and borrow dropped
   always_comb begin
      case (op)
         OP_ADD:  alu = a + BusWires;
         OP_SUB:  alu = a - BusWires;
         OP_AND:  alu = a & BusWires;
         OP_OR:   alu = a | BusWires;
         default: alu = '0;
      endcase
   end

   // Datapath registers; reset wins over any pending write
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ir    <= '0;
         a     <= '0;
         g     <= '0;
         Zflag <= 1'b0;
         for (int i = 0; i < 8; i++)
            r[i] <= '0;
      end else begin
         if (ir_in) ir <= DIN[8:0];
         if (a_in)  a  <= BusWires;
         if (g_in) begin
            g     <= alu;
            Zflag <= (alu == '0);
         end
         for (int i = 0; i < 8; i++)
            if (r_in[i]) r[i] <= BusWires;
      end
   end

endmodule

// File: tb/tb_proc_gen.sv
// tb_proc_gen: randomized and directed checks of proc_gen against an
// instruction-level model of registers, Zflag and per-step bus/Done.
module tb_proc_gen;

   localparam int N = 16;

   logic         Clock;
   logic         Reset;
   logic         Run;
   logic [N-1:0] DIN;
   logic         Done;
   logic [N-1:0] BusWires;
   logic         Zflag;

   proc_gen #(.N(N)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Run      (Run),
      .DIN      (DIN),
      .Done     (Done),
      .BusWires (BusWires),
      .Zflag    (Zflag)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [N-1:0] mr [8];
   logic         mz;

   bit           check_en;
   logic         exp_done;
   logic [N-1:0] exp_bus;
   logic         exp_z;
   int           n_tests;
   int           n_fail;

   // Every cycle: Done, bus and Zflag against the model's expectation
   always @(negedge Clock) begin
      if (check_en) begin
         n_tests++;
         if (Done !== exp_done || BusWires !== exp_bus ||
             Zflag !== exp_z) begin
            n_fail++;
            $display("FAIL cycle t=%0t: done=%b bus=%h z=%b, need done=%b bus=%h z=%b",
                     $time, Done, BusWires, Zflag,
                     exp_done, exp_bus, exp_z);
         end
      end
   end

   task automatic lit(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) mr[i] = '0;
      mz = 1'b0;
   endtask

   // Drive one cycle's inputs and the outputs the model predicts for it
   task automatic cyc(input bit rs, input bit rn, input logic [N-1:0] d,
                      input bit ed, input logic [N-1:0] eb);
      @(posedge Clock);
      #1;
      Reset    = rs;
      Run      = rn;
      DIN      = d;
      exp_done = ed;
      exp_bus  = eb;
      exp_z    = mz;
      check_en = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, N'($urandom), 0, '0);
   endtask

   // One instruction; abort_at = 1..3 asserts Reset in that step
   task automatic instr(input logic [2:0] op, input logic [2:0] x,
                        input logic [2:0] y, input logic [N-1:0] imm,
                        input int abort_at);
      logic [N-1:0] w;
      logic [N-1:0] av;
      logic [N-1:0] res;
      logic [N-1:0] eb;
      w = N'($urandom);
      w[8:0] = {op, x, y};
      cyc(0, 1, w, 0, '0);
      if (op == 3'b000 || op == 3'b001 || op[2:1] == 2'b11) begin
         case (op)
            3'b000:  eb = mr[y];
            3'b001:  eb = imm;
            3'b110:  eb = mz ? '0 : mr[y];
            default: eb = '0;
         endcase
         cyc(abort_at == 1, 1'($urandom),
             (op == 3'b001) ? imm : N'($urandom), 1, eb);
         if (abort_at == 1) begin
            clear_model();
            return;
         end
         if (op == 3'b000 || op == 3'b001 || (op == 3'b110 && !mz))
            mr[x] = eb;
      end else begin
         cyc(abort_at == 1, 1'($urandom), N'($urandom), 0, mr[x]);
         if (abort_at == 1) begin
            clear_model();
            return;
         end
         av = mr[x];
         cyc(abort_at == 2, 1'($urandom), N'($urandom), 0, mr[y]);
         if (abort_at == 2) begin
            clear_model();
            return;
         end
         case (op)
            3'b010:  res = av + mr[y];
            3'b011:  res = av - mr[y];
            3'b100:  res = av & mr[y];
            default: res = av | mr[y];
         endcase
         mz = (res == '0);
         cyc(abort_at == 3, 1'($urandom), N'($urandom), 1, res);
         if (abort_at == 3) begin
            clear_model();
            return;
         end
         mr[x] = res;
      end
   endtask

   // mv rd,rs then sample the bus in its T1 against a literal
   task automatic peek(input string name, input logic [2:0] rs,
                       input logic [N-1:0] exp);
      instr(3'b000, 3'd7, rs, '0, 0);
      #1;
      lit(name, BusWires, exp);
   endtask

   initial begin
      check_en = 1'b0;
      n_tests  = 0;
      n_fail   = 0;
      Reset    = 1'b1;
      Run      = 1'b0;
      DIN      = '0;
      exp_done = 1'b0;
      exp_bus  = '0;
      exp_z    = 1'b0;
      clear_model();

      cyc(1, 0, '0, 0, '0);
      cyc(1, 0, '0, 0, '0);
      idle(3);
      for (int i = 0; i < 8; i++) peek("reset_reg", 3'(i), 16'h0000);

      instr(3'b001, 3'd0, 3'd0, 16'h1234, 0);
      instr(3'b000, 3'd1, 3'd0, '0, 0);
      #1;
      lit("mv_bus", BusWires, 16'h1234);
      lit("mv_done", {15'd0, Done}, 16'h0001);
      lit("model_r1", mr[1], 16'h1234);

      instr(3'b001, 3'd0, 3'd0, 16'hFFFF, 0);
      instr(3'b001, 3'd1, 3'd0, 16'h0001, 0);
      instr(3'b010, 3'd0, 3'd1, '0, 0);
      lit("add_z", {15'd0, Zflag}, 16'h0001);
      peek("add_r0", 3'd0, 16'h0000);
      instr(3'b011, 3'd0, 3'd1, '0, 0);
      lit("sub_z", {15'd0, Zflag}, 16'h0000);
      peek("sub_r0", 3'd0, 16'hFFFF);

      instr(3'b001, 3'd2, 3'd0, 16'h00F0, 0);
      instr(3'b001, 3'd3, 3'd0, 16'h0F0F, 0);
      instr(3'b100, 3'd2, 3'd3, '0, 0);
      lit("and_z", {15'd0, Zflag}, 16'h0001);
      peek("and_r2", 3'd2, 16'h0000);
      instr(3'b101, 3'd3, 3'd2, '0, 0);
      peek("or_r3", 3'd3, 16'h0F0F);

      instr(3'b100, 3'd2, 3'd3, '0, 0);
      instr(3'b110, 3'd4, 3'd3, '0, 0);
      peek("mvnz_hold", 3'd4, 16'h0000);
      instr(3'b011, 3'd0, 3'd1, '0, 0);
      instr(3'b110, 3'd4, 3'd3, '0, 0);
      peek("mvnz_move", 3'd4, 16'h0F0F);

      instr(3'b111, 3'd5, 3'd3, '0, 0);
      instr(3'b010, 3'd2, 3'd2, '0, 0);
      instr(3'b001, 3'd6, 3'd0, 16'h8001, 0);
      instr(3'b010, 3'd6, 3'd6, '0, 0);
      peek("double", 3'd6, 16'h0002);

      instr(3'b010, 3'd0, 3'd1, '0, 2);
      idle(1);
      peek("abort_r0", 3'd0, 16'h0000);
      peek("abort_r3", 3'd3, 16'h0000);
      instr(3'b001, 3'd2, 3'd0, 16'hABCD, 0);
      peek("post_mvi", 3'd2, 16'hABCD);

      for (int k = 0; k < 400; k++) begin
         int ab;
         ab = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 3)) : 0;
         instr(3'($urandom), 3'($urandom), 3'($urandom),
               N'($urandom), ab);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      @(posedge Clock);
      #1;
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
